// File: rtl/rr_grant_sequencer.sv
// Four-requester round-robin arbiter with bounded grant hold.
// Drives the y/en select of a downstream 2x4 decoder; all outputs are registered.
module rr_grant_sequencer #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  output logic [1:0]        gnt_idx,
  output logic              gnt_en,
  output logic              gnt_new,
  output logic [HOLD_W-1:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        ptr_reg, ptr_next;
  logic [1:0]        idx_reg, idx_next;
  logic              en_reg, en_next;
  logic              new_reg, new_next;
  logic [HOLD_W-1:0] cnt_reg, cnt_next;
  logic              release_now;
  logic [1:0]        pick_ptr;
  logic [1:0]        pick_idx;

  // First set bit of m scanning p, p+1, p+2, p+3 (mod 4); scanning backwards
  // lets the earliest hit in priority order overwrite later ones.
  function automatic logic [1:0] sel(input logic [1:0] p, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] c;
    r = p;
    for (int k = 3; k >= 0; k--) begin
      c = p + 2'(k);
      if (m[c]) r = c;
    end
    return r;
  endfunction

  assign release_now = !req[idx_reg] || (cnt_reg == HOLD_W'(MAX_HOLD));
  assign pick_ptr    = (state_reg == GRANT) ? (idx_reg + 2'd1) : ptr_reg;
  assign pick_idx    = sel(pick_ptr, req);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    en_next    = en_reg;
    new_next   = 1'b0;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req != 4'b0000) begin
          idx_next   = pick_idx;
          en_next    = 1'b1;
          new_next   = 1'b1;
          cnt_next   = HOLD_W'(1);
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!release_now) begin
          cnt_next = cnt_reg + HOLD_W'(1);
        end else begin
          ptr_next = pick_ptr;
          if (req != 4'b0000) begin
            idx_next = pick_idx;
            new_next = 1'b1;
            cnt_next = HOLD_W'(1);
          end else begin
            en_next    = 1'b0;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      idx_reg   <= 2'd0;
      en_reg    <= 1'b0;
      new_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      en_reg    <= en_next;
      new_reg   <= new_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign gnt_idx  = idx_reg;
  assign gnt_en   = en_reg;
  assign gnt_new  = new_reg;
  assign hold_cnt = cnt_reg;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops
// and compares them after each clock edge on the selected arbiter instance.
module tb_rr_grant_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;

  logic [1:0] idx8, idx3, idx1;
  logic       en8, en3, en1;
  logic       nw8, nw3, nw1;
  logic [3:0] cnt8, cnt3, cnt1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         d;
    logic [1:0] idx;
    logic       en;
    logic       nw;
    logic [3:0] cnt;
    string      nm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rr_grant_sequencer #(.MAX_HOLD(8), .HOLD_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt_idx(idx8), .gnt_en(en8), .gnt_new(nw8), .hold_cnt(cnt8));
  rr_grant_sequencer #(.MAX_HOLD(3), .HOLD_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt_idx(idx3), .gnt_en(en3), .gnt_new(nw3), .hold_cnt(cnt3));
  rr_grant_sequencer #(.MAX_HOLD(1), .HOLD_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt_idx(idx1), .gnt_en(en1), .gnt_new(nw1), .hold_cnt(cnt1));

  // One cycle of stimulus plus the outputs expected after the following edge.
  task automatic cyc(input logic rn, input logic [3:0] r, input int d,
                     input logic [1:0] ei, input logic ee, input logic enw,
                     input logic [3:0] ec, input string nm);
    exp_t e;
    rst_n = rn;
    req   = r;
    e.d = d; e.idx = ei; e.en = ee; e.nw = enw; e.cnt = ec; e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: each edge presents a new output set; compare against the queue head.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      logic [1:0] ai;
      logic       ae, an;
      logic [3:0] ac;
      e = sb.pop_front();
      case (e.d)
        3:       begin ai = idx3; ae = en3; an = nw3; ac = cnt3; end
        1:       begin ai = idx1; ae = en1; an = nw1; ac = cnt1; end
        default: begin ai = idx8; ae = en8; an = nw8; ac = cnt8; end
      endcase
      checks++;
      if (ai !== e.idx || ae !== e.en || an !== e.nw || ac !== e.cnt) begin
        errors++;
        $display("FAIL %s dut%0d: got idx=%0d en=%b new=%b cnt=%0d, need idx=%0d en=%b new=%b cnt=%0d",
                 e.nm, e.d == 0 ? 8 : e.d, ai, ae, an, ac, e.idx, e.en, e.nw, e.cnt);
      end else begin
        $display("ok   %s dut%0d: idx=%0d en=%b new=%b cnt=%0d",
                 e.nm, e.d == 0 ? 8 : e.d, ai, ae, an, ac);
      end
    end
  end

  initial begin
    int k;
    // 1. reset and idle
    cyc(0, 4'b1111, 0, 2'd0, 0, 0, 4'd0, "rst0");
    cyc(0, 4'b1111, 0, 2'd0, 0, 0, 4'd0, "rst1");
    cyc(1, 4'b0000, 0, 2'd0, 0, 0, 4'd0, "idle0");
    cyc(1, 4'b0000, 0, 2'd0, 0, 0, 4'd0, "idle1");
    // 2. single request
    cyc(1, 4'b0100, 0, 2'd2, 1, 1, 4'd1, "single_c1");
    cyc(1, 4'b0100, 0, 2'd2, 1, 0, 4'd2, "single_c2");
    cyc(1, 4'b0100, 0, 2'd2, 1, 0, 4'd3, "single_c3");
    cyc(1, 4'b0000, 0, 2'd2, 0, 0, 4'd0, "single_drop");
    // 3. round robin with back-to-back handover
    cyc(0, 4'b0000, 0, 2'd0, 0, 0, 4'd0, "rr_rst");
    cyc(1, 4'b1111, 0, 2'd0, 1, 1, 4'd1, "rr_g0a");
    cyc(1, 4'b1111, 0, 2'd0, 1, 0, 4'd2, "rr_g0b");
    cyc(1, 4'b1110, 0, 2'd1, 1, 1, 4'd1, "rr_g1a");
    cyc(1, 4'b1110, 0, 2'd1, 1, 0, 4'd2, "rr_g1b");
    cyc(1, 4'b1100, 0, 2'd2, 1, 1, 4'd1, "rr_g2a");
    cyc(1, 4'b1100, 0, 2'd2, 1, 0, 4'd2, "rr_g2b");
    cyc(1, 4'b1000, 0, 2'd3, 1, 1, 4'd1, "rr_g3a");
    cyc(1, 4'b1000, 0, 2'd3, 1, 0, 4'd2, "rr_g3b");
    cyc(1, 4'b0111, 0, 2'd0, 1, 1, 4'd1, "rr_wrap0");
    cyc(1, 4'b0000, 0, 2'd0, 0, 0, 4'd0, "rr_idle");
    // 4. hold limit 8 with two competing requesters
    cyc(0, 4'b0000, 0, 2'd0, 0, 0, 4'd0, "hold_rst");
    for (k = 0; k < 17; k++)
      cyc(1, 4'b0011, 0, (k >= 8 && k < 16) ? 2'd1 : 2'd0, 1, (k % 8) == 0,
          4'((k % 8) + 1), $sformatf("hold_k%0d", k));
    cyc(1, 4'b0000, 0, 2'd0, 0, 0, 4'd0, "hold_idle");
    // 6. reset mid-grant (ptr is 1 here, so idx2 is picked first)
    cyc(1, 4'b0100, 0, 2'd2, 1, 1, 4'd1, "mid_c1");
    cyc(1, 4'b0100, 0, 2'd2, 1, 0, 4'd2, "mid_c2");
    cyc(1, 4'b0100, 0, 2'd2, 1, 0, 4'd3, "mid_c3");
    cyc(1, 4'b0100, 0, 2'd2, 1, 0, 4'd4, "mid_c4");
    cyc(0, 4'b0100, 0, 2'd0, 0, 0, 4'd0, "mid_rst");
    cyc(1, 4'b0110, 0, 2'd1, 1, 1, 4'd1, "mid_after");
    // 5. lone requester expiry with limit 3
    cyc(0, 4'b0000, 3, 2'd0, 0, 0, 4'd0, "lone_rst");
    for (k = 0; k < 6; k++)
      cyc(1, 4'b1000, 3, 2'd3, 1, (k % 3) == 0, 4'((k % 3) + 1),
          $sformatf("lone_k%0d", k));
    cyc(1, 4'b0000, 3, 2'd3, 0, 0, 4'd0, "lone_idle");
    // limit 1: re-arbitrate every cycle
    cyc(0, 4'b0000, 1, 2'd0, 0, 0, 4'd0, "mh1_rst");
    for (k = 0; k < 4; k++)
      cyc(1, 4'b0011, 1, 2'(k % 2), 1, 1, 4'd1, $sformatf("mh1_k%0d", k));
    cyc(1, 4'b0000, 1, 2'd1, 0, 0, 4'd0, "mh1_idle");

    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, need 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
